// File: rtl/uart_tx_sched_if.sv
// Bundle between the packet scheduler, its requesters and the uart_tx byte transmitter.
// The master modport is the scheduler's view of the bus; slave is the opposite side.
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_i;
    logic [8*NUM_REQ-1:0] len_i;
    logic [8*NUM_REQ-1:0] data_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic [NUM_REQ-1:0]   data_rd_o;
    logic [NUM_REQ-1:0]   done_o;
    logic                 uart_tx_en_o;
    logic [7:0]           uart_txdata_o;
    logic                 uart_tx_busy_i;
    logic                 sched_busy_o;

    modport master (
        input  req_i, len_i, data_i, uart_tx_busy_i,
        output grant_o, data_rd_o, done_o, uart_tx_en_o, uart_txdata_o, sched_busy_o
    );

    modport slave (
        output req_i, len_i, data_i, uart_tx_busy_i,
        input  grant_o, data_rd_o, done_o, uart_tx_en_o, uart_txdata_o, sched_busy_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler feeding one uart_tx: frames HDR, LEN, payload, CHK per grant
// and paces every byte through the uart_tx enable/busy handshake.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ  = 2,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    uart_tx_sched_if.master bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LENB = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;

    localparam logic [1:0] BS_ISSUE   = 2'd0;
    localparam logic [1:0] BS_WAIT_HI = 2'd1;
    localparam logic [1:0] BS_WAIT_LO = 2'd2;

    logic [2:0]         r_state, w_state_nxt;
    logic [1:0]         r_bstate, w_bstate_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic [7:0]         r_chk, w_chk_nxt;
    logic [7:0]         r_txdata, w_txdata_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_data_rd, w_data_rd_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               r_en, w_en_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [7:0]         w_win_len;
    logic [7:0]         w_pay_byte;
    logic [7:0]         w_byte;
    int unsigned        w_cand;

    // First requesting index at or after the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_cand = 32'(r_ptr) + 32'(k);
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && bus.req_i[IDX_W'(w_cand)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(w_cand);
            end
        end
    end

    // Per-requester byte selects for the arbitration winner and the current owner.
    always_comb begin
        w_win_len  = '0;
        w_pay_byte = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win == IDX_W'(i)) w_win_len = bus.len_i[8*i +: 8];
            if (r_idx == IDX_W'(i)) w_pay_byte = bus.data_i[8*i +: 8];
        end
        case (r_state)
            ST_HDR:  w_byte = HDR_BYTE;
            ST_LENB: w_byte = r_cnt;
            ST_PAY:  w_byte = w_pay_byte;
            default: w_byte = r_chk;
        endcase
    end

    // Packet FSM with the per-byte issue/wait handshake nested inside each frame state.
    always_comb begin
        w_state_nxt   = r_state;
        w_bstate_nxt  = r_bstate;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_chk_nxt     = r_chk;
        w_txdata_nxt  = r_txdata;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_data_rd_nxt = '0;
        w_done_nxt    = '0;
        w_en_nxt      = 1'b0;

        if (r_state == ST_IDLE) begin
            if (w_found) begin
                w_state_nxt  = ST_HDR;
                w_bstate_nxt = BS_ISSUE;
                w_idx_nxt    = w_win;
                w_grant_nxt  = NUM_REQ'(1) << w_win;
                w_cnt_nxt    = w_win_len;
                w_chk_nxt    = 8'd0;
                w_busy_nxt   = 1'b1;
                w_ptr_nxt    = (32'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
            end
        end else begin
            case (r_bstate)
                BS_ISSUE: begin
                    if (!bus.uart_tx_busy_i) begin
                        w_en_nxt     = 1'b1;
                        w_txdata_nxt = w_byte;
                        w_bstate_nxt = BS_WAIT_HI;
                        if (r_state == ST_LENB) begin
                            w_chk_nxt = r_chk + r_cnt;
                        end
                        if (r_state == ST_PAY) begin
                            w_chk_nxt     = r_chk + w_pay_byte;
                            w_data_rd_nxt = r_grant;
                            if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
                        end
                    end
                end
                BS_WAIT_HI: begin
                    if (bus.uart_tx_busy_i) w_bstate_nxt = BS_WAIT_LO;
                end
                BS_WAIT_LO: begin
                    if (!bus.uart_tx_busy_i) begin
                        w_bstate_nxt = BS_ISSUE;
                        case (r_state)
                            ST_HDR:          w_state_nxt = ST_LENB;
                            ST_LENB, ST_PAY: w_state_nxt = (r_cnt == 8'd0) ? ST_CHK : ST_PAY;
                            ST_CHK: begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = r_grant;
                                w_grant_nxt = '0;
                                w_busy_nxt  = 1'b0;
                            end
                            default: begin
                                w_state_nxt = ST_IDLE;
                                w_grant_nxt = '0;
                                w_busy_nxt  = 1'b0;
                            end
                        endcase
                    end
                end
                default: w_bstate_nxt = BS_ISSUE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_bstate  <= BS_ISSUE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_chk     <= '0;
            r_txdata  <= '0;
            r_grant   <= '0;
            r_data_rd <= '0;
            r_done    <= '0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bstate  <= w_bstate_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_chk     <= w_chk_nxt;
            r_txdata  <= w_txdata_nxt;
            r_grant   <= w_grant_nxt;
            r_data_rd <= w_data_rd_nxt;
            r_done    <= w_done_nxt;
            r_en      <= w_en_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.grant_o       = r_grant;
    assign bus.data_rd_o     = r_data_rd;
    assign bus.done_o        = r_done;
    assign bus.uart_tx_en_o  = r_en;
    assign bus.uart_txdata_o = r_txdata;
    assign bus.sched_busy_o  = r_busy;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: uart_tx and requester models plus a frame-level
// reference (rr pick, HDR/LEN/payload/CHK) compared against every transmitted byte.
module tb_uart_tx_sched;
    localparam int unsigned N   = 2;
    localparam logic [7:0]  HDR = 8'hA5;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    uart_tx_sched_if #(.NUM_REQ(N)) bus ();

    uart_tx_sched #(.NUM_REQ(N), .HDR_BYTE(HDR)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state
    logic [7:0]   src_q [N][$];
    logic [7:0]   obs_q[$];
    logic [7:0]   exp_q[$];
    int           win_log[$];
    int           rr_ptr = 0;
    int           cur    = 0;
    int           n_rd   = 0;
    int           n_done = 0;
    int           bcnt   = 0;
    logic         busy_m    = 1'b0;
    logic         ext_busy  = 1'b0;
    logic         stall_req = 1'b0;
    logic         stable_bad = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [7:0]   last_byte  = '0;

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < int'(N); k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic start_packet();
        int         w;
        logic [7:0] len;
        logic [7:0] sum;
        logic [7:0] b;
        w = rr_pick(rr_ptr, bus.req_i);
        if (w < 0) begin
            check("grant_without_req", 32'(bus.grant_o), 0);
            w = 0;
        end else begin
            check("grant_rr", 32'(bus.grant_o), 32'(1) << w);
        end
        check("sched_busy_up", 32'(bus.sched_busy_o), 1);
        rr_ptr = (w + 1) % N;
        cur = w;
        win_log.push_back(w);
        len = 8'(bus.len_i >> (8 * w));
        obs_q.delete();
        exp_q.delete();
        n_rd = 0;
        exp_q.push_back(HDR);
        exp_q.push_back(len);
        sum = len;
        for (int k = 0; k < int'(len); k++) begin
            b = (k < src_q[w].size()) ? src_q[w][k] : 8'h00;
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(sum);
    endtask

    task automatic end_packet();
        check("done_onehot", 32'(bus.done_o), 32'(1) << cur);
        check("grant_clear", 32'(bus.grant_o), 0);
        check("sched_busy_clear", 32'(bus.sched_busy_o), 0);
        check("frame_len", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check($sformatf("frame_byte%0d", k), 32'(obs_q[k]), 32'(exp_q[k]));
        check("rd_pulses", 32'(n_rd), 32'(exp_q.size() - 3));
        n_done++;
    endtask

    // uart_tx model, requester data model and frame monitor, sampled 1 time unit after posedge
    initial begin
        bus.data_i         = '0;
        bus.uart_tx_busy_i = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!sys_rst_n) begin
                rr_ptr     = 0;
                obs_q.delete();
                exp_q.delete();
                busy_m     = 1'b0;
                bcnt       = 0;
                prev_grant = '0;
                n_rd       = 0;
            end else begin
                if (bus.grant_o != '0 && prev_grant == '0) start_packet();
                if (bus.data_rd_o != '0) begin
                    check("data_rd_owner", 32'(bus.data_rd_o), 32'(bus.grant_o));
                    n_rd++;
                    if (src_q[cur].size() > 0) void'(src_q[cur].pop_front());
                end
                if (bus.uart_tx_en_o) begin
                    check("en_while_busy", 32'(bus.uart_tx_busy_i), 0);
                    obs_q.push_back(bus.uart_txdata_o);
                    last_byte = bus.uart_txdata_o;
                    busy_m    = 1'b1;
                    bcnt      = stall_req ? 500 : int'($urandom_range(4, 1));
                    stall_req = 1'b0;
                end else if (bcnt > 0) begin
                    if (bus.uart_txdata_o !== last_byte) stable_bad = 1'b1;
                    bcnt--;
                    if (bcnt == 0) busy_m = 1'b0;
                end
                if (bus.done_o != '0) end_packet();
                prev_grant = bus.grant_o;
            end
            for (int r = 0; r < int'(N); r++)
                bus.data_i[8*r +: 8] = (src_q[r].size() > 0) ? src_q[r][0] : 8'h00;
            bus.uart_tx_busy_i = busy_m | ext_busy;
        end
    end

    task automatic load_req(input int r, input int len);
        src_q[r].delete();
        for (int k = 0; k < len; k++) src_q[r].push_back(8'($urandom));
        bus.len_i[8*r +: 8] = 8'(len);
    endtask

    task automatic wait_done(input int target, input int limit);
        int t = 0;
        while (n_done < target && t < limit) begin
            @(negedge sys_clk);
            t++;
        end
        check("done_timeout", 32'(n_done >= target), 1);
    endtask

    task automatic wait_grant(input int limit);
        int t = 0;
        while (!bus.sched_busy_o && t < limit) begin
            @(negedge sys_clk);
            t++;
        end
        check("grant_timeout", 32'(bus.sched_busy_o), 1);
    endtask

    task automatic wait_obs(input int n, input int limit);
        int t = 0;
        while (obs_q.size() < n && t < limit) begin
            @(negedge sys_clk);
            t++;
        end
        check("byte_timeout", 32'(obs_q.size() >= n), 1);
    endtask

    // Drops each requester's req (and scrambles its len) once granted, until target packets are done.
    task automatic serve(input int target, input int limit);
        int t = 0;
        while (n_done < target && t < limit) begin
            @(negedge sys_clk);
            for (int r = 0; r < int'(N); r++) begin
                if (bus.grant_o[r] && bus.req_i[r]) begin
                    bus.req_i[r] = 1'b0;
                    bus.len_i[8*r +: 8] = 8'($urandom);
                end
            end
            t++;
        end
        check("serve_timeout", 32'(n_done >= target), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},   32'(bus.grant_o), 0);
        check({tag, "_data_rd"}, 32'(bus.data_rd_o), 0);
        check({tag, "_done"},    32'(bus.done_o), 0);
        check({tag, "_en"},      32'(bus.uart_tx_en_o), 0);
        check({tag, "_txdata"},  32'(bus.uart_txdata_o), 0);
        check({tag, "_busy"},    32'(bus.sched_busy_o), 0);
    endtask

    initial begin
        logic [7:0]   t1_exp[$];
        logic [N-1:0] pat;
        int           base;
        int           d0;
        int           t;

        bus.req_i = '0;
        bus.len_i = '0;
        repeat (3) @(negedge sys_clk);
        check_idle_outputs("rst");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single packet from requester 0
        src_q[0].delete();
        src_q[0].push_back(8'h11);
        src_q[0].push_back(8'h22);
        src_q[0].push_back(8'h33);
        bus.len_i[7:0] = 8'd3;
        bus.req_i = 2'b01;
        wait_grant(20);
        bus.req_i = '0;
        wait_done(1, 400);
        t1_exp = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        check("t1_en_count", 32'(obs_q.size()), 6);
        for (int k = 0; k < 6 && k < obs_q.size(); k++)
            check($sformatf("t1_byte%0d", k), 32'(obs_q[k]), 32'(t1_exp[k]));
        check("t1_rd_count", 32'(n_rd), 3);

        // Zero-length packet from requester 1
        load_req(1, 0);
        bus.req_i = 2'b10;
        wait_grant(20);
        bus.req_i = '0;
        wait_done(2, 400);
        check("t2_winner", 32'(win_log[win_log.size()-1]), 1);
        check("t2_en_count", 32'(obs_q.size()), 3);
        if (obs_q.size() == 3) begin
            check("t2_hdr", 32'(obs_q[0]), 32'(HDR));
            check("t2_len", 32'(obs_q[1]), 0);
            check("t2_chk", 32'(obs_q[2]), 0);
        end
        check("t2_rd_count", 32'(n_rd), 0);

        // Round robin with both requests held
        base = win_log.size();
        load_req(0, 2);
        load_req(1, 2);
        bus.len_i = {8'd1, 8'd1};
        bus.req_i = 2'b11;
        wait_done(6, 2000);
        bus.req_i = '0;
        for (int k = 0; k < 4; k++)
            if (base + k < win_log.size())
                check($sformatf("rr_order%0d", k), 32'(win_log[base+k]), 32'(k % 2));
        check("rr_count", 32'(win_log.size() - base), 4);

        // Busy stall: held before the first byte, then 500 cycles after it
        load_req(0, 2);
        ext_busy = 1'b1;
        repeat (2) @(negedge sys_clk);
        bus.req_i = 2'b01;
        wait_grant(20);
        bus.req_i = '0;
        repeat (50) @(negedge sys_clk);
        check("stall_no_en", 32'(obs_q.size()), 0);
        stall_req = 1'b1;
        ext_busy  = 1'b0;
        wait_obs(1, 100);
        repeat (400) @(negedge sys_clk);
        check("stall_hold", 32'(obs_q.size()), 1);
        wait_done(7, 2000);
        check("txdata_stable", 32'(stable_bad), 0);

        // req drop after the header byte
        load_req(0, 2);
        bus.req_i = 2'b01;
        wait_grant(20);
        wait_obs(1, 100);
        bus.req_i = '0;
        wait_done(8, 400);
        check("drop_en_count", 32'(obs_q.size()), 5);

        // Randomised request patterns and lengths
        for (int it = 0; it < 8; it++) begin
            pat = 2'($urandom_range(3, 1));
            for (int r = 0; r < int'(N); r++)
                if (pat[r]) load_req(r, int'($urandom_range(6, 0)));
            bus.req_i = pat;
            serve(n_done + $countones(pat), 3000);
        end

        // Async reset during payload
        load_req(0, 5);
        bus.req_i = 2'b01;
        wait_grant(20);
        bus.req_i = '0;
        t = 0;
        while (n_rd < 1 && t < 400) begin
            @(negedge sys_clk);
            t++;
        end
        check("rst_pay_reached", 32'(n_rd >= 1), 1);
        d0 = n_done;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        repeat (3) @(negedge sys_clk);
        src_q[0].delete();
        src_q[1].delete();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_no_done", 32'(n_done), 32'(d0));
        load_req(0, 1);
        load_req(1, 1);
        bus.req_i = 2'b11;
        wait_grant(20);
        check("post_rst_winner", 32'(win_log[win_log.size()-1]), 0);
        serve(d0 + 2, 2000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
